// File: rtl/alu_rr_sched_pkg.sv
// Shared definitions for the stage ALU round-robin scheduler: FSM encoding,
// page-entry field layout and opcode field width.
package alu_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned PT_BASE_LSB = 0;
  localparam int unsigned PT_LEN_LSB  = 8;
  localparam int unsigned PT_FIELD_W  = 8;

  // Opcode occupies the top OPCODE_W bits of an action word.
  localparam int unsigned OPCODE_W = 8;

  function automatic logic [PT_FIELD_W-1:0] pt_len(input logic [15:0] entry);
    return entry[PT_LEN_LSB +: PT_FIELD_W];
  endfunction

  function automatic logic [PT_FIELD_W-1:0] pt_base(input logic [15:0] entry);
    return entry[PT_BASE_LSB +: PT_FIELD_W];
  endfunction

endpackage

// File: rtl/alu_rr_sched_arbiter.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping; returns one-hot grant, binary index and an any-valid flag.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // N is a power of two, so the IW-bit add wraps modulo N for free.
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one stateful ALU among NUM_REQ requesters;
// holds the per-requester page table and returns results one at a time.
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ACTION_LEN = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ACTION_LEN-1:0]   req_action,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op2,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op3,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]           resp_data,
  input  logic                            cfg_wr_en,
  input  logic [$clog2(NUM_REQ)-1:0]      cfg_idx,
  input  logic [PT_WIDTH-1:0]             cfg_data,
  output logic [ACTION_LEN-1:0]           alu_action,
  output logic                            alu_action_valid,
  output logic [DATA_WIDTH-1:0]           alu_op1,
  output logic [DATA_WIDTH-1:0]           alu_op2,
  output logic [DATA_WIDTH-1:0]           alu_op3,
  input  logic                            alu_ready,
  output logic [PT_WIDTH-1:0]             alu_page_tbl,
  output logic                            alu_page_tbl_valid,
  input  logic [DATA_WIDTH-1:0]           alu_result,
  input  logic                            alu_result_valid,
  output logic                            alu_result_ready
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic [ACTION_LEN-1:0]  action_q, action_d;
  logic [DATA_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [PT_WIDTH-1:0]    pt_entry_q, pt_entry_d;
  logic                   act_vld_q, act_vld_d;
  logic                   pt_vld_q, pt_vld_d;
  logic                   res_rdy_q, res_rdy_d;
  logic [PT_WIDTH-1:0]    pt_q [NUM_REQ];
  logic [PT_WIDTH-1:0]    pt_d [NUM_REQ];

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   arb_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    req_ready_d  = '0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    action_d     = action_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    op3_d        = op3_q;
    pt_entry_d   = pt_entry_q;
    act_vld_d    = 1'b0;
    pt_vld_d     = pt_vld_q;
    res_rdy_d    = res_rdy_q;
    pt_d         = pt_q;
    if (cfg_wr_en) pt_d[cfg_idx] = cfg_data;

    // Outputs are registered, so each state sets up what is visible in the next one.
    unique case (state_q)
      ST_IDLE: begin
        if (alu_ready && arb_any) begin
          state_d     = ST_ISSUE;
          grant_d     = arb_idx;
          req_ready_d = arb_gnt;
          action_d    = req_action[arb_idx*ACTION_LEN +: ACTION_LEN];
          op1_d       = req_op1[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          op2_d       = req_op2[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          op3_d       = req_op3[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          pt_entry_d  = pt_q[arb_idx];
          pt_vld_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        act_vld_d = 1'b1;
        res_rdy_d = 1'b1;
        rr_ptr_d  = grant_q + 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_result_valid) begin
          resp_data_d           = alu_result;
          resp_valid_d          = '0;
          resp_valid_d[grant_q] = 1'b1;
          res_rdy_d             = 1'b0;
          pt_vld_d              = 1'b0;
          state_d               = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      action_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      op3_q        <= '0;
      pt_entry_q   <= '0;
      act_vld_q    <= 1'b0;
      pt_vld_q     <= 1'b0;
      res_rdy_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) pt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      action_q     <= action_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      op3_q        <= op3_d;
      pt_entry_q   <= pt_entry_d;
      act_vld_q    <= act_vld_d;
      pt_vld_q     <= pt_vld_d;
      res_rdy_q    <= res_rdy_d;
      pt_q         <= pt_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign resp_valid         = resp_valid_q;
  assign resp_data          = resp_data_q;
  assign alu_action         = action_q;
  assign alu_action_valid   = act_vld_q;
  assign alu_op1            = op1_q;
  assign alu_op2            = op2_q;
  assign alu_op3            = op3_q;
  assign alu_page_tbl       = pt_entry_q;
  assign alu_page_tbl_valid = pt_vld_q;
  assign alu_result_ready   = res_rdy_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: the bench plays the requesters and the ALU
// and checks grants, issue timing, page entries and result return.
module tb_alu_rr_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [255:0] req_action = '0;
  logic [127:0] req_op1 = '0, req_op2 = '0, req_op3 = '0;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready = '1;
  logic [31:0]  resp_data;
  logic         cfg_wr_en = 1'b0;
  logic [1:0]   cfg_idx = '0;
  logic [15:0]  cfg_data = '0;
  logic [63:0]  alu_action;
  logic         alu_action_valid;
  logic [31:0]  alu_op1, alu_op2, alu_op3;
  logic         alu_ready = 1'b1;
  logic [15:0]  alu_page_tbl;
  logic         alu_page_tbl_valid;
  logic [31:0]  alu_result = '0;
  logic         alu_result_valid = 1'b0;
  logic         alu_result_ready;

  logic [63:0]  exp_act [4];
  logic [31:0]  exp_op1 [4], exp_op2 [4], exp_op3 [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(
    .NUM_REQ(4), .ACTION_LEN(64), .DATA_WIDTH(32), .PT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
    .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .alu_action(alu_action), .alu_action_valid(alu_action_valid),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
    .alu_ready(alu_ready), .alu_page_tbl(alu_page_tbl),
    .alu_page_tbl_valid(alu_page_tbl_valid), .alu_result(alu_result),
    .alu_result_valid(alu_result_valid), .alu_result_ready(alu_result_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 0);
    check({tag, "_resp_data"}, 64'(resp_data), 0);
    check({tag, "_action"}, alu_action, 0);
    check({tag, "_ops12"}, {alu_op1, alu_op2}, 0);
    check({tag, "_op3_pt"}, {alu_op3, alu_page_tbl}, 0);
    check({tag, "_ctl"}, {alu_action_valid, alu_page_tbl_valid, alu_result_ready}, 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    resp_ready = '1;
    alu_ready = 1'b1;
    alu_result_valid = 1'b0;
    cfg_wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] data);
    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_idx = 2'(idx); cfg_data = data;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic load_payload(input int i, input logic [63:0] a,
                              input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] o3);
    req_action[i*64 +: 64] = a;
    req_op1[i*32 +: 32] = o1;
    req_op2[i*32 +: 32] = o2;
    req_op3[i*32 +: 32] = o3;
    exp_act[i] = a; exp_op1[i] = o1; exp_op2[i] = o2; exp_op3[i] = o3;
  endtask

  task automatic wait_grant(output int gi, output int waited);
    gi = -1;
    waited = 0;
    for (int c = 0; c < 40 && gi < 0; c++) begin
      @(negedge clk);
      waited++;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
    end
    check("grant_seen", 64'(gi >= 0), 1);
    if (gi >= 0) check("ready_onehot", 64'($countones(req_ready)), 1);
  endtask

  // Grant, issue, ALU reply at T+3, result at T+4, optional response hold.
  task automatic run_txn(input int exp_gi, input logic [15:0] exp_pt, input logic [31:0] res,
                         input int hold, input bit drop, output int waited);
    int gi;
    wait_grant(gi, waited);
    check("grant_idx", 64'(gi), 64'(exp_gi));
    if (gi < 0) return;
    check("pt_at_grant", 64'(alu_page_tbl), 64'(exp_pt));
    check("pt_vld_at_grant", 64'(alu_page_tbl_valid), 1);
    check("act_vld_at_grant", 64'(alu_action_valid), 0);
    @(posedge clk); #1;
    if (drop) req_valid[gi] = 1'b0;
    if (hold > 0) resp_ready = ~(4'b0001 << gi);
    @(negedge clk);
    check("act_vld_T1", 64'(alu_action_valid), 1);
    check("action_T1", alu_action, exp_act[gi]);
    check("op12_T1", {alu_op1, alu_op2}, {exp_op1[gi], exp_op2[gi]});
    check("op3_T1", 64'(alu_op3), 64'(exp_op3[gi]));
    check("res_rdy_T1", 64'(alu_result_ready), 1);
    check("no_ready_T1", 64'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("act_vld_T2", 64'(alu_action_valid), 0);
    @(posedge clk); #1;
    alu_result_valid = 1'b1; alu_result = res;
    @(negedge clk);
    check("no_resp_T3", 64'(resp_valid), 0);
    @(posedge clk); #1;
    alu_result_valid = 1'b0; alu_result = ~res;
    @(negedge clk);
    check("resp_valid_T4", 64'(resp_valid), 64'(4'b0001 << gi));
    check("resp_data_T4", 64'(resp_data), 64'(res));
    check("res_rdy_T4", 64'(alu_result_ready), 0);
    check("pt_vld_T4", 64'(alu_page_tbl_valid), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'(4'b0001 << gi));
      check("hold_data", 64'(resp_data), 64'(res));
      check("hold_no_grant", 64'(req_ready), 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      resp_ready = '1;
    end
  endtask

  initial begin
    int w;
    #2;
    check_reset_outs("por");
    @(negedge clk);
    rst = 1'b0;

    // Single store request from requester 0.
    cfg_write(0, 16'h1004);
    load_payload(0, {8'h08, 56'h0}, 32'h55, 32'h3, 32'h0);
    req_valid = 4'b0001;
    run_txn(0, 16'h1004, 32'h0000_00AA, 0, 1'b1, w);

    // Fairness with all four requesters continuously valid.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_payload(i, {8'h10 + 8'(i), 24'h0, 32'hCAFE_0000 + 32'(i)},
                   32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i));
      cfg_write(i, 16'h0100 + 16'(i));
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++)
      run_txn(k % 4, 16'h0100 + 16'(k % 4), 32'h1000 + 32'(k), 0, 1'b0, w);
    req_valid = 4'b0000;

    // Back-pressure on requester 2, then requester 0 follows.
    req_valid = 4'b0101;
    run_txn(2, 16'h0102, 32'hBEEF_0002, 10, 1'b1, w);
    run_txn(0, 16'h0100, 32'hBEEF_0000, 0, 1'b1, w);

    // Page-table write in the same cycle as requester 1's grant.
    @(posedge clk); #1;
    req_valid = 4'b0010;
    cfg_wr_en = 1'b1; cfg_idx = 2'd1; cfg_data = 16'h2010;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    run_txn(1, 16'h0101, 32'h0000_1111, 0, 1'b1, w);
    req_valid = 4'b0010;
    run_txn(1, 16'h2010, 32'h0000_2222, 0, 1'b1, w);

    // ALU busy: no grant while alu_ready is low.
    alu_ready = 1'b0;
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("busy_no_grant", 64'(req_ready), 0);
    end
    @(posedge clk); #1;
    alu_ready = 1'b1;
    run_txn(3, 16'h0103, 32'h0000_3333, 0, 1'b1, w);
    check("busy_grant_latency", 64'(w), 2);

    // Advance rr_ptr to 3, then reset during WAIT.
    req_valid = 4'b0010;
    run_txn(1, 16'h2010, 32'h0000_4444, 0, 1'b1, w);
    req_valid = 4'b0100;
    begin
      int gi;
      wait_grant(gi, w);
      check("rst_pre_grant", 64'(gi), 2);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    alu_result_valid = 1'b1; alu_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    alu_result_valid = 1'b0;
    @(negedge clk);
    check("stray_result_valid", 64'(resp_valid), 0);
    check("stray_result_data", 64'(resp_data), 0);
    req_valid = 4'b1011;
    run_txn(0, 16'h0000, 32'h0000_5555, 0, 1'b1, w);
    req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

endmodule
